mul_seq_ctrl: RTL and testbench

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

---
 rtl/mul_seq_pkg.sv | 16 +
 rtl/slice_mul2.sv | 28 ++
 rtl/mul_seq_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mul_seq_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared definitions for the digit-serial multiplier controller: FSM state
// encoding, default operand size and the digit / partial-product widths.
package mul_seq_pkg;

    localparam int N_DIG_DEFAULT = 4;
    localparam int DIG_W         = 2;
    localparam int PP_W          = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/slice_mul2.sv
// 2x2 unsigned multiplier slice with a registered 4-bit result.
// Built from two conditional adds so no generic multiplier is inferred.
module slice_mul2
    import mul_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [DIG_W-1:0] x,
    input  logic [DIG_W-1:0] y,
    output logic [PP_W-1:0]  p
);

    logic [PP_W-1:0] p_next;

    // Partial product: x*y[0] plus x*y[1] shifted left by one.
    always_comb begin
        p_next = '0;
        if (y[0]) p_next = p_next + {2'b00, x};
        if (y[1]) p_next = p_next + {1'b0, x, 1'b0};
    end

    // Register the partial product, giving the one-cycle slice latency.
    always_ff @(posedge clk) begin
        if (reset) p <= '0;
        else       p <= p_next;
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential multiplier controller: multiplies two unsigned operands of
// N_DIG 2-bit digits by feeding digit pairs through a single 2x2 slice and
// shift-adding the partial products into an accumulator.
// Optional build macro MUL_SEQ_SKIP_ZERO_EN: skip every zero digit of
// operand a (its whole row of pairs is not issued).
module mul_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int N_DIG = N_DIG_DEFAULT
)
(
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [2*N_DIG-1:0]                a,
    input  logic [2*N_DIG-1:0]                b,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [4*N_DIG-1:0]                product,
    output logic                              busy,
    output logic [$clog2(N_DIG*N_DIG+1)-1:0] mac_cnt
);

    localparam int OW = DIG_W * N_DIG;
    localparam int PW = 2 * OW;
    localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int SW = $clog2(4 * N_DIG);
    localparam int MW = $clog2(N_DIG * N_DIG + 1);

    state_t state;
    state_t next_state;

    logic [OW-1:0]    a_lat;
    logic [OW-1:0]    b_lat;
    logic [IW-1:0]    dig_i;
    logic [IW-1:0]    dig_j;
    logic [PW-1:0]    acc;
    logic [MW-1:0]    mac_q;
    logic             pp_valid;
    logic [SW-1:0]    pp_shift;
    logic [PP_W-1:0]  pp;
    logic [DIG_W-1:0] a_dig;
    logic [DIG_W-1:0] b_dig;

    logic             accept;
    logic             issue;
    logic             last_j;
    logic             first_any;
    logic [IW-1:0]    first_idx;
    logic             next_any;
    logic [IW-1:0]    next_idx;

    assign a_dig   = a_lat[DIG_W*dig_i +: DIG_W];
    assign b_dig   = b_lat[DIG_W*dig_j +: DIG_W];
    assign last_j  = (dig_j == IW'(N_DIG - 1));
    assign product = acc;
    assign mac_cnt = mac_q;

    slice_mul2 u_slice (
        .clk   (clk),
        .reset (reset),
        .x     (a_dig),
        .y     (b_dig),
        .p     (pp)
    );

`ifdef MUL_SEQ_SKIP_ZERO_EN
    int first_pos;
    int next_pos;

    // Lowest non-zero digit of v at or above position 'from'; N_DIG if none.
    function automatic int first_nz_from(input logic [OW-1:0] v, input int from);
        int r;
        r = N_DIG;
        for (int k = N_DIG - 1; k >= 0; k--) begin
            if (k >= from && v[DIG_W*k +: DIG_W] != '0) r = k;
        end
        return r;
    endfunction

    // Row selection skips zero A digits: first row from the incoming operand,
    // next row from the latched one.
    always_comb begin
        first_pos = first_nz_from(a, 0);
        next_pos  = first_nz_from(a_lat, int'(dig_i) + 1);
        first_any = (first_pos < N_DIG);
        first_idx = IW'(first_pos);
        next_any  = (next_pos < N_DIG);
        next_idx  = IW'(next_pos);
    end
`else
    // Every A digit is visited in order, starting at digit 0.
    always_comb begin
        first_any = 1'b1;
        first_idx = '0;
        next_any  = (dig_i != IW'(N_DIG - 1));
        next_idx  = dig_i + IW'(1);
    end
`endif

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = first_any ? RUN : DRAIN;
            RUN:     if (last_j && !next_any) next_state = DRAIN;
            DRAIN:   next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        issue     = (state == RUN);
        accept    = in_valid && (state == IDLE);
    end

    // Datapath: operand capture, digit indices, issue count, and the
    // accumulation of each partial product one cycle after it was issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_lat    <= '0;
            b_lat    <= '0;
            dig_i    <= '0;
            dig_j    <= '0;
            acc      <= '0;
            mac_q    <= '0;
            pp_valid <= 1'b0;
            pp_shift <= '0;
        end else begin
            pp_valid <= issue;
            pp_shift <= SW'({dig_i, 1'b0}) + SW'({dig_j, 1'b0});
            if (accept) begin
                a_lat <= a;
                b_lat <= b;
                acc   <= '0;
                mac_q <= '0;
                dig_i <= first_idx;
                dig_j <= '0;
            end else begin
                if (pp_valid) begin
                    acc <= acc + (PW'(pp) << pp_shift);
                end
                if (issue) begin
                    mac_q <= mac_q + MW'(1);
                    if (last_j) begin
                        dig_j <= '0;
                        dig_i <= next_idx;
                    end else begin
                        dig_j <= dig_j + IW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed testbench for mul_seq_ctrl at the default N_DIG=4.
// Expected issue counts and latencies follow MUL_SEQ_SKIP_ZERO_EN when defined.
module tb_mul_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;
    logic [4:0]  mac_cnt;

    int passed;
    int total;

    mul_seq_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy),
        .mac_cnt   (mac_cnt)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of 2x2 multiplies expected for operand a.
    function automatic int exp_issues(input logic [7:0] va);
        int n;
        n = 0;
`ifdef MUL_SEQ_SKIP_ZERO_EN
        for (int k = 0; k < 4; k++) begin
            if (((va >> (2*k)) & 8'h03) != 8'h00) n = n + 4;
        end
`else
        n = 16;
`endif
        return n;
    endfunction

    // Offer one operand pair from IDLE, scramble the inputs after accept and
    // return the cycle index (accept cycle = 0) at which out_valid appears.
    task automatic do_op(input logic [7:0] va, input logic [7:0] vb, output int lat);
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = 8'($urandom);
        b        = 8'($urandom);
        lat      = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        int lat;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if (product !== 16'h0000) $display("[TB] FAIL reset_product got %h want 0000", product); else passed++;
        total++; if (mac_cnt !== 5'd0) $display("[TB] FAIL reset_mac_cnt got %0d want 0", mac_cnt); else passed++;
        // accept in the very first cycle after reset deasserts
        reset     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 8'h05;
        b         = 8'h07;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (busy !== 1'b1) $display("[TB] FAIL first_accept_busy got %b want 1", busy); else passed++;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        total++; if (product !== 16'h0023) $display("[TB] FAIL first_accept_product got %h want 0023", product); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_full_ones();
        int lat;
        out_ready = 1'b1;
        do_op(8'hFF, 8'hFF, lat);
        total++; if (lat !== 18) $display("[TB] FAIL ff_latency got %0d want 18", lat); else passed++;
        total++; if (product !== 16'hFE01) $display("[TB] FAIL ff_product got %h want FE01", product); else passed++;
        total++; if (mac_cnt !== 5'd16) $display("[TB] FAIL ff_mac_cnt got %0d want 16", mac_cnt); else passed++;
        total++; if (in_ready !== 1'b0) $display("[TB] FAIL ff_in_ready_in_done got %b want 0", in_ready); else passed++;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL ff_back_to_idle got in_ready=%b busy=%b want 1/0", in_ready, busy); else passed++;
        total++; if (product !== 16'hFE01) $display("[TB] FAIL ff_product_held_idle got %h want FE01", product); else passed++;
        total++; if (mac_cnt !== 5'd16) $display("[TB] FAIL ff_mac_held_idle got %0d want 16", mac_cnt); else passed++;
    endtask

    task automatic test_mixed();
        int lat;
        out_ready = 1'b1;
        do_op(8'hA5, 8'h3C, lat);
        total++; if (lat !== 18) $display("[TB] FAIL a5_latency got %0d want 18", lat); else passed++;
        total++; if (product !== 16'h26AC) $display("[TB] FAIL a5_product got %h want 26AC", product); else passed++;
        total++; if (mac_cnt !== 5'd16) $display("[TB] FAIL a5_mac_cnt got %0d want 16", mac_cnt); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_skip_zero();
        int lat;
        int exp_n;
        out_ready = 1'b1;
        exp_n = exp_issues(8'h03);
        do_op(8'h03, 8'hC0, lat);
        total++; if (lat !== exp_n + 2) $display("[TB] FAIL sparse_latency got %0d want %0d", lat, exp_n + 2); else passed++;
        total++; if (product !== 16'h0240) $display("[TB] FAIL sparse_product got %h want 0240", product); else passed++;
        total++; if (mac_cnt !== 5'(exp_n)) $display("[TB] FAIL sparse_mac_cnt got %0d want %0d", mac_cnt, exp_n); else passed++;
        @(posedge clk); #1;
        exp_n = exp_issues(8'h00);
        do_op(8'h00, 8'h77, lat);
        total++; if (lat !== exp_n + 2) $display("[TB] FAIL zero_latency got %0d want %0d", lat, exp_n + 2); else passed++;
        total++; if (product !== 16'h0000) $display("[TB] FAIL zero_product got %h want 0000", product); else passed++;
        total++; if (mac_cnt !== 5'(exp_n)) $display("[TB] FAIL zero_mac_cnt got %0d want %0d", mac_cnt, exp_n); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_hold_done();
        int lat;
        out_ready = 1'b0;
        do_op(8'h12, 8'h34, lat);
        total++; if (lat !== exp_issues(8'h12) + 2) $display("[TB] FAIL hold_latency got %0d want %0d", lat, exp_issues(8'h12) + 2); else passed++;
        // offer a new pair while the product waits; it must be ignored
        in_valid = 1'b1;
        a        = 8'h77;
        b        = 8'h99;
        for (int c = 0; c < 5; c++) begin
            total++; if (product !== 16'h03A8) $display("[TB] FAIL hold_product cycle %0d got %h want 03A8", c, product); else passed++;
            total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) $display("[TB] FAIL hold_handshake cycle %0d got in_ready=%b out_valid=%b want 0/1", c, in_ready, out_valid); else passed++;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("[TB] FAIL hold_release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); else passed++;
        total++; if (product !== 16'h03A8) $display("[TB] FAIL hold_product_after got %h want 03A8", product); else passed++;
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int seen;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 8'hFF;
        b         = 8'hFF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        total++; if (busy !== 1'b1) $display("[TB] FAIL midrun_busy got %b want 1", busy); else passed++;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL midrun_idle got in_ready=%b busy=%b want 1/0", in_ready, busy); else passed++;
        total++; if (product !== 16'h0000) $display("[TB] FAIL midrun_product got %h want 0000", product); else passed++;
        total++; if (mac_cnt !== 5'd0) $display("[TB] FAIL midrun_mac_cnt got %0d want 0", mac_cnt); else passed++;
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        total++; if (seen !== 0) $display("[TB] FAIL midrun_no_out_valid got %0d pulses want 0", seen); else passed++;
        do_op(8'h02, 8'h03, lat);
        total++; if (product !== 16'h0006) $display("[TB] FAIL after_reset_product got %h want 0006", product); else passed++;
        total++; if (lat !== exp_issues(8'h02) + 2) $display("[TB] FAIL after_reset_latency got %0d want %0d", lat, exp_issues(8'h02) + 2); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0]  va [3];
        logic [7:0]  vb [3];
        logic [15:0] vp [3];
        int lat;
        va[0] = 8'h01; vb[0] = 8'h01; vp[0] = 16'h0001;
        va[1] = 8'hFF; vb[1] = 8'h01; vp[1] = 16'h00FF;
        va[2] = 8'h80; vb[2] = 8'h80; vp[2] = 16'h4000;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            do_op(va[k], vb[k], lat);
            total++; if (product !== vp[k]) $display("[TB] FAIL b2b_product[%0d] got %h want %h", k, product, vp[k]); else passed++;
            total++; if (lat !== exp_issues(va[k]) + 2) $display("[TB] FAIL b2b_latency[%0d] got %0d want %0d", k, lat, exp_issues(va[k]) + 2); else passed++;
            total++; if (mac_cnt !== 5'(exp_issues(va[k]))) $display("[TB] FAIL b2b_mac_cnt[%0d] got %0d want %0d", k, mac_cnt, exp_issues(va[k])); else passed++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        test_reset();
        test_full_ones();
        test_mixed();
        test_skip_zero();
        test_hold_done();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
